// File: rtl/matvec_sequencer_pkg.sv
// Shared types and default parameters for the matrix-vector sequencer.
package matvec_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int N_DEF     = 32;
  localparam int B_DEF     = 8;
  localparam int LEN_DEF   = 4;
  localparam int WIDTH_DEF = 4;

endpackage

// File: rtl/matvec_sequencer_dotprod.sv
// Combinational signed fixed-point dot product: sum(a[i]*b[i]) >>> B, truncated to N bits.
module DotProd
  import matvec_sequencer_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int B   = B_DEF,
  parameter int LEN = LEN_DEF
) (
  input  logic [LEN-1:0][N-1:0] a,
  input  logic [LEN-1:0][N-1:0] b,
  output logic [N-1:0]          y
);

  localparam int AW = 2*N + $clog2(LEN) + 1;

  logic signed [AW-1:0]  acc;
  logic signed [2*N-1:0] prod;

  // Accumulate at full precision so the only loss is the final scaling.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int unsigned i = 0; i < LEN; i++) begin
      prod = $signed(a[i]) * $signed(b[i]);
      acc  = acc + AW'(prod);
    end
    y = N'(acc >>> B);
  end

endmodule

// File: rtl/matvec_sequencer.sv
// Streams WIDTH matrix rows through one dot-product unit against a captured vector.
module matvec_sequencer
  import matvec_sequencer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int B     = B_DEF,
  parameter int LEN   = LEN_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN-1:0][N-1:0]   vec_in,
  input  logic                    abort,
  input  logic                    row_valid,
  output logic                    row_ready,
  input  logic [LEN-1:0][N-1:0]   row_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_data,
  output logic [IW-1:0]           out_idx,
  output logic                    out_last,
  output logic [WIDTH-1:0][N-1:0] vec_out,
  output logic                    busy,
  output logic                    done
);

  state_e                  state_q, state_d;
  logic [LEN-1:0][N-1:0]   vec_q, vec_d;
  logic [IW-1:0]           row_cnt_q, row_cnt_d;
  logic [IW-1:0]           out_idx_q, out_idx_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;
  logic [N-1:0]            out_data_q, out_data_d;
  logic [WIDTH-1:0][N-1:0] vec_out_q, vec_out_d;

  logic [N-1:0] dot;
  logic         row_acc;
  logic         out_acc;
  logic         row_is_last;

  DotProd #(
    .N   (N),
    .B   (B),
    .LEN (LEN)
  ) u_dot (
    .a (row_data),
    .b (vec_q),
    .y (dot)
  );

  assign row_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
  assign row_acc     = row_valid && row_ready;
  assign out_acc     = out_valid_q && out_ready;
  assign row_is_last = (row_cnt_q == IW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    row_cnt_d   = row_cnt_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    vec_out_d   = vec_out_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // done_q marks the completion cycle, where a pending start must not launch a job.
        if (start && !abort && !done_q) begin
          state_d   = RUN;
          vec_d     = vec_in;
          row_cnt_d = '0;
        end
      end
      RUN, FLUSH: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          if (out_acc) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
          // Applied after the drain so a same-cycle row reloads the output with no bubble.
          if (row_acc) begin
            out_valid_d          = 1'b1;
            out_data_d           = dot;
            out_idx_d            = row_cnt_q;
            out_last_d           = row_is_last;
            vec_out_d[row_cnt_q] = dot;
            if (row_is_last) begin
              row_cnt_d = '0;
              state_d   = FLUSH;
            end else begin
              row_cnt_d = row_cnt_q + IW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      row_cnt_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      vec_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      row_cnt_q   <= row_cnt_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
      vec_out_q   <= vec_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign vec_out   = vec_out_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed, table-driven checks of the matrix-vector sequencer.
module tb_matvec_sequencer;

  localparam int N     = 32;
  localparam int B     = 8;
  localparam int LEN   = 4;
  localparam int WIDTH = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic [LEN-1:0][N-1:0]   vec_in;
  logic                    abort;
  logic                    row_valid;
  logic                    row_ready;
  logic [LEN-1:0][N-1:0]   row_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [N-1:0]            out_data;
  logic [1:0]              out_idx;
  logic                    out_last;
  logic [WIDTH-1:0][N-1:0] vec_out;
  logic                    busy;
  logic                    done;

  matvec_sequencer #(
    .N     (N),
    .B     (B),
    .LEN   (LEN),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_in    (vec_in),
    .abort     (abort),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .vec_out   (vec_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LEN-1:0][N-1:0] row;
    logic [N-1:0]          exp;
  } vec_t;

  vec_t                  tab[WIDTH];
  logic [LEN-1:0][N-1:0] vec256;
  logic [LEN-1:0][N-1:0] vec512;
  int                    total = 0;
  int                    bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Entered and left at a sampling point (1 time unit after a rising edge).
  task automatic start_job(input logic [LEN-1:0][N-1:0] v, input bit hold);
    start  = 1'b1;
    vec_in = v;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_no_valid", out_valid, 0);
  endtask

  task automatic run_job(input int stall, input int gap);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int dones = 0;
    int stall_left = stall;
    while (got < WIDTH && cyc < 200) begin
      if (done) dones++;
      row_valid = (sent < WIDTH) && (cyc % gap == 0);
      row_data  = tab[sent % WIDTH].row;
      if (out_valid && got == 0 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && !out_ready) begin
        chk("bp_row_ready", row_ready, 0);
        chk("bp_hold_data", out_data, tab[got].exp);
        chk("bp_hold_idx", out_idx, got);
      end
      if (row_valid && row_ready) sent++;
      if (out_valid && out_ready) begin
        chk("res_data", out_data, tab[got].exp);
        chk("res_idx", out_idx, got);
        chk("res_last", out_last, (got == WIDTH - 1));
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    row_valid = 1'b0;
    chk("job_complete", got, WIDTH);
    if (stall == 0 && gap == 1) chk("throughput_cycles", cyc, WIDTH + 1);
    chk("done_not_early", dones, 0);
    chk("done_pulse", done, 1);
    chk("done_idle", busy, 0);
    for (int i = 0; i < WIDTH; i++) chk("vec_out_full", vec_out[i], tab[i].exp);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("post_done_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec256 = {4{32'd256}};
    vec512 = {4{32'd512}};
    tab[0].row = {32'd0, 32'd0, 32'd512, 32'd256};     tab[0].exp = 32'd768;
    tab[1].row = {32'd256, 32'd256, 32'd256, 32'd256}; tab[1].exp = 32'd1024;
    tab[2].row = {32'd0, 32'd0, 32'd0, 32'hFFFFFF00};  tab[2].exp = 32'hFFFFFF00;
    tab[3].row = {32'd0, 32'd0, 32'd3, 32'd128};       tab[3].exp = 32'd131;

    rst_n = 1'b0; start = 1'b0; vec_in = '0; abort = 1'b0;
    row_valid = 1'b0; row_data = '0; out_ready = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_row_ready", row_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    for (int i = 0; i < WIDTH; i++) chk("rst_vec_out", vec_out[i], 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Rows offered in IDLE are refused; abort beats start in IDLE.
    row_valid = 1'b1; row_data = tab[0].row; out_ready = 1'b1;
    #1;
    chk("idle_row_ready", row_ready, 0);
    @(posedge clk); #1;
    chk("idle_no_valid", out_valid, 0);
    row_valid = 1'b0;
    abort = 1'b1; start = 1'b1; vec_in = vec256;
    @(posedge clk); #1;
    chk("abort_over_start", busy, 0);
    abort = 1'b0; start = 1'b0;

    start_job(vec256, 0); run_job(0, 1);
    start_job(vec256, 0); run_job(5, 1);
    start_job(vec256, 0); run_job(0, 3);

    // Abort after two rows with a different vector.
    start_job(vec512, 0);
    row_valid = 1'b1; out_ready = 1'b1; row_data = tab[0].row;
    @(posedge clk); #1;
    chk("ab_data0", out_data, 32'd1536);
    row_data = tab[1].row;
    @(posedge clk); #1;
    chk("ab_data1", out_data, 32'd2048);
    chk("ab_idx1", out_idx, 1);
    row_valid = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_out_valid", out_valid, 0);
    chk("ab_done", done, 0);
    chk("ab_vec0", vec_out[0], 32'd1536);
    chk("ab_vec1", vec_out[1], 32'd2048);
    chk("ab_vec2", vec_out[2], tab[2].exp);
    chk("ab_vec3", vec_out[3], tab[3].exp);
    @(posedge clk); #1;
    chk("ab_no_done", done, 0);
    start_job(vec256, 0); run_job(0, 1);

    // start held high across a job: no recapture while busy or on the done cycle.
    start_job(vec256, 1);
    vec_in = vec512;
    run_job(0, 1);
    @(posedge clk); #1;
    chk("restart_after_done", busy, 1);
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("cleanup_idle", busy, 0);

    // Reset mid-RUN with a result pending.
    start_job(vec256, 0);
    row_valid = 1'b1; row_data = tab[0].row; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("mr_valid", out_valid, 1);
    chk("mr_data", out_data, 32'd768);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_data", out_data, 0);
    chk("mr_out_idx", out_idx, 0);
    chk("mr_out_last", out_last, 0);
    chk("mr_done", done, 0);
    chk("mr_row_ready", row_ready, 0);
    for (int i = 0; i < WIDTH; i++) chk("mr_vec_out", vec_out[i], 0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mr_release_row_ready", row_ready, 0);
      @(posedge clk); #1;
      chk("mr_release_busy", busy, 0);
      chk("mr_release_valid", out_valid, 0);
    end
    row_valid = 1'b0;
    start_job(vec256, 0); run_job(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matvec_sequencer.md
MATVEC_SEQUENCER -- requirements
Module: matvec_sequencer

Interface
REQ-001 Parameter N, default 32: element and result word width in bits.
REQ-002 Parameter B, default 8: number of fractional bits in each fixed-point word, passed unchanged to the dot-product unit.
REQ-003 Parameter LEN, default 4: vector length, which is also the number of elements per matrix row.
REQ-004 Parameter WIDTH, default 4: number of matrix rows, which is also the number of results per job.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port start, input, 1 bit: job request, sampled only in IDLE.
REQ-008 Port vec_in, input, N bits x LEN: vector operand, captured when start is accepted.
REQ-009 Port abort, input, 1 bit: synchronous job cancel.
REQ-010 Port row_valid, input, 1 bit: row_data holds a valid matrix row.
REQ-011 Port row_ready, output, 1 bit: the block accepts a row this cycle.
REQ-012 Port row_data, input, N bits x LEN: one matrix row.
REQ-013 Port out_valid, output, 1 bit: out_data holds a valid result.
REQ-014 Port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-015 Port out_data, output, N bits: one result element.
REQ-016 Port out_idx, output, $clog2(WIDTH) bits: row index of out_data.
REQ-017 Port out_last, output, 1 bit: asserted with the result for row WIDTH-1.
REQ-018 Port vec_out, output, N bits x WIDTH: holds all results of the most recent completed job.
REQ-019 Port busy, output, 1 bit: the state is not IDLE.
REQ-020 Port done, output, 1 bit: one-cycle pulse when a job completes.

Function
REQ-021 States shall be IDLE, RUN and FLUSH, with transitions as follows:
- IDLE to RUN when start=1, capturing vec_in into an internal vector register;
- RUN to FLUSH when row WIDTH-1 is accepted;
- FLUSH to IDLE when the out_last beat is accepted.
REQ-022 A row handshake (row_valid and row_ready both high) is required for a row to be accepted.
REQ-023 row_ready shall be RUN and (not out_valid, or out_ready).
REQ-024 row_ready shall be 0 in IDLE and in FLUSH.
REQ-025 A single shared DotProd instance shall compute the product of the accepted row and the captured vector combinationally.
REQ-026 The DotProd result shall be registered into out_data on the accepting edge, so that out_valid rises exactly 1 cycle after the row is accepted.
REQ-027 out_idx shall equal row_cnt at the time of acceptance, and row_cnt shall increment from 0 to WIDTH-1.
REQ-028 Each result shall also be written to vec_out[out_idx] on the accepting edge.
REQ-029 Any other vec_out entries shall keep their previous values until overwritten.
REQ-030 out_data, out_idx and out_last shall stay stable while out_valid=1 and out_ready=0.
REQ-031 When out_valid=1 and out_ready=0, row_ready shall be 0 and no row shall be lost.
REQ-032 A row acceptance and an output acceptance in the same cycle shall load the next result with no bubble, sustaining 1 row per cycle.
REQ-033 done shall pulse for 1 cycle on the edge after the out_last beat is accepted, coincident with the return to IDLE.
REQ-034 start asserted while busy=1 shall be ignored, including in the same cycle that done pulses.
REQ-035 row_valid asserted in IDLE or FLUSH shall not be accepted.
REQ-036 The arithmetic result shall be the DotProd output unmodified: N bits, B fractional bits, with no extra saturation or rounding in this block.
REQ-037 abort=1 in RUN or FLUSH shall return the block to IDLE on the next edge.
REQ-038 On abort, out_valid shall be cleared, done shall not pulse, and vec_out shall keep its partial contents.
REQ-039 abort in IDLE shall have no effect; abort has priority over start.
REQ-040 For WIDTH=1, the first accepted row shall take the block directly to FLUSH, with out_last=1.

Reset
REQ-041 While rst_n=0, the block shall be in state IDLE immediately and asynchronously.
REQ-042 While rst_n=0, row_cnt and out_idx shall be 0, and the vector register and vec_out shall be all zero.
REQ-043 While rst_n=0, out_valid, out_last, out_data, busy, done and row_ready shall all be 0.
REQ-044 Reset asserted mid-job shall discard the job; after reset release, the block shall wait for a new start.

Structure
REQ-045 A shared package shall hold the state enum type (IDLE, RUN, FLUSH) and the default values for N, B, LEN and WIDTH.
REQ-046 The existing DotProd shall be the only sub-module, instantiated once as #(N,B,LEN).

Verification
REQ-047 Basic job: start with vec_in all 256 (1.0), then rows {256,512,0,0} and so on, with out_ready held at 1. Required response: out_data=768 (3.0) for row 0, one result per cycle, out_last on index 3, and done 1 cycle after the last beat.
REQ-048 Backpressure: out_ready=0 for 5 cycles after the first result. Required response: out_data stays stable, row_ready=0 throughout, no row is dropped, and all 4 indices appear in order.
REQ-049 Intermittent row_valid (1 of every 3 cycles). Required response: results match the rows, vec_out is complete, and done pulses exactly once.
REQ-050 abort after 2 rows. Required response: IDLE and busy=0 on the next cycle, no done, vec_out[0..1] updated and vec_out[2..3] unchanged; a following job completes normally.
REQ-051 rst_n pulled low mid-RUN. Required response: all outputs are 0 asynchronously, and rows offered after release are not accepted until start.
REQ-052 start held high throughout a job and row_valid driven while IDLE. Required response: no second capture while busy, and no row acceptance in IDLE.
